move_gen_arbiter: RTL and testbench

- Shares the single move-generator ("modify") engine among NUM_REQ requesters: checkmate sweep, player-selection highlighter and check detector.
- Accepts per-requester square requests and grants them round-robin.
- For each grant, pulses the generator's start input with the square, waits for generator done, then returns the 64-bit move mask to the granted requester.
- Sits between the game controllers and the move generator.

---
 rtl/chess_pkg.sv | 27 ++
 rtl/move_gen_arbiter_rr_pick.sv | 33 +++
 rtl/move_gen_arbiter.sv | 134 +++++++++++++
 tb/tb_move_gen_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess-engine types: board/move widths, arbiter FSM states and piece helpers.
package chess_pkg;

  localparam int SQ_W      = 6;
  localparam int PIECE_W   = 4;
  localparam int BOARD_W   = 256;
  localparam int MOVES_W   = 64;
  localparam int COLOR_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    DELIVER
  } arb_state_t;

  function automatic logic [PIECE_W-1:0] board_piece(input logic [BOARD_W-1:0] board,
                                                     input logic [SQ_W-1:0]    sq);
    return board[int'(sq)*PIECE_W +: PIECE_W];
  endfunction

  function automatic logic piece_color(input logic [PIECE_W-1:0] piece);
    return piece[COLOR_BIT];
  endfunction

endpackage

// File: rtl/move_gen_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] winner,
  output logic [N-1:0]     winner_oh
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    // Offset 1..N puts the previous winner last in line.
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign any       = found;
  assign winner_oh = found ? (N'(1) << winner) : '0;

endmodule

// File: rtl/move_gen_arbiter.sv
// Round-robin owner of the shared move generator: issue square, await done, return mask.
// Optional WAIT watchdog enabled by defining MOVEGEN_TIMEOUT_EN.
module move_gen_arbiter
  import chess_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SQ_W-1:0] req_pos,
  output logic                    gen_start,
  output logic [SQ_W-1:0]         gen_pos,
  input  logic                    gen_ready,
  input  logic [MOVES_W-1:0]      gen_moves,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [MOVES_W-1:0]      resp_moves,
  output logic                    resp_timeout,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("move_gen_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("move_gen_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   last;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [SQ_W-1:0]    pos_sel;
  logic               timeout_hit;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req),
    .last      (last),
    .any       (pick_any),
    .winner    (pick_idx),
    .winner_oh (pick_oh)
  );

  always_comb begin
    pos_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pos_sel = req_pos[i*SQ_W +: SQ_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ARM exists because gen_ready may still be high from the generator's idle period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT:    if (gen_ready || timeout_hit) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gen_start  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DELIVER) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      gen_pos    <= '0;
      last       <= IDX_W'(NUM_REQ - 1);
      resp_moves <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant   <= pick_oh;
            gen_pos <= pos_sel;
            last    <= pick_idx;
          end
        end
        WAIT: begin
          if (gen_ready)        resp_moves <= gen_moves;
          else if (timeout_hit) resp_moves <= '0;
        end
        DELIVER: grant <= '0;
        default: ;
      endcase
    end
  end

`ifdef MOVEGEN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

  logic [TO_W-1:0] wait_cnt;
  logic            to_flag;

  // Counter holds the number of completed WAIT cycles; it fires on the last allowed one.
  always_ff @(posedge clk) begin
    if (reset)                wait_cnt <= '0;
    else if (state == ARM)    wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && !gen_ready &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                 to_flag <= 1'b0;
    else if (timeout_hit)      to_flag <= 1'b1;
    else if (state == DELIVER) to_flag <= 1'b0;
  end

  assign resp_timeout = (state == DELIVER) && to_flag;
`else
  assign timeout_hit  = 1'b0;
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_move_gen_arbiter.sv
// Directed bench for move_gen_arbiter with a behavioural move-generator model.
module tb_move_gen_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [17:0] req_pos;
  logic        gen_start;
  logic [5:0]  gen_pos;
  logic        gen_ready;
  logic [63:0] gen_moves;
  logic [2:0]  grant;
  logic [2:0]  resp_valid;
  logic [63:0] resp_moves;
  logic        resp_timeout;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

  int          gm_lat   = 2;
  int          gm_cnt   = 0;
  bit          gm_stale = 1'b0;
  logic [63:0] gm_moves = '0;

  typedef struct {
    logic [2:0]  req;
    logic [17:0] pos;
    int          lat;
    bit          stale;
    logic [63:0] moves;
    logic [2:0]  exp_grant;
    logic [5:0]  exp_pos;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  move_gen_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_pos      (req_pos),
    .gen_start    (gen_start),
    .gen_pos      (gen_pos),
    .gen_ready    (gen_ready),
    .gen_moves    (gen_moves),
    .grant        (grant),
    .resp_valid   (resp_valid),
    .resp_moves   (resp_moves),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Generator: on start, mask goes to garbage; gm_lat cycles later the real mask appears
  // with ready. In stale mode ready never drops.
  always @(negedge clk) begin
    if (gen_start) begin
      gen_moves = GARBAGE;
      gm_cnt    = gm_lat;
      if (!gm_stale) gen_ready = 1'b0;
    end else if (gm_cnt > 0) begin
      gm_cnt = gm_cnt - 1;
      if (gm_cnt == 0) begin
        gen_moves = gm_moves;
        gen_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_grant"},        64'(grant),        64'd0);
    chk({pfx, "_resp_valid"},   64'(resp_valid),   64'd0);
    chk({pfx, "_resp_moves"},   resp_moves,        64'd0);
    chk({pfx, "_gen_start"},    64'(gen_start),    64'd0);
    chk({pfx, "_gen_pos"},      64'(gen_pos),      64'd0);
    chk({pfx, "_resp_timeout"}, 64'(resp_timeout), 64'd0);
    chk({pfx, "_busy"},         64'(busy),         64'd0);
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int         lat_seen = -1;
    int         starts   = 0;
    int         pulses   = 0;
    logic [2:0] g_seen   = '0;
    logic [2:0] rv       = '0;
    logic [5:0] pos_st   = '0;
    logic [5:0] pos_dl   = '0;
    logic       to_seen  = 1'b0;
    gm_lat   = v.lat;
    gm_stale = v.stale;
    gm_moves = v.moves;
    req      = v.req;
    req_pos  = v.pos;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (gen_start) begin
        starts++;
        pos_st = gen_pos;
        g_seen = grant;
      end
      if (resp_valid != 3'b000) begin
        if (lat_seen < 0) begin
          lat_seen = k;
          rv       = resp_valid;
          pos_dl   = gen_pos;
          to_seen  = resp_timeout;
        end
        pulses++;
        req = 3'b000;
      end
      if (lat_seen > 0 && k >= lat_seen + 2) break;
    end
    chk({name, "_grant"},      64'(g_seen),   64'(v.exp_grant));
    chk({name, "_starts"},     64'(starts),   64'd1);
    chk({name, "_gen_pos"},    64'(pos_st),   64'(v.exp_pos));
    chk({name, "_pos_stable"}, 64'(pos_dl),   64'(v.exp_pos));
    chk({name, "_pulses"},     64'(pulses),   64'd1);
    chk({name, "_resp_valid"}, 64'(rv),       64'(v.exp_grant));
    chk({name, "_latency"},    64'(lat_seen), 64'(v.exp_lat));
    chk({name, "_moves"},      resp_moves,    v.moves);
    chk({name, "_timeout"},    64'(to_seen),  64'd0);
    chk({name, "_busy_after"}, 64'(busy),     64'd0);
    chk({name, "_grant_after"},64'(grant),    64'd0);
  endtask

  initial begin
    vecs[0] = '{3'b001, {6'd0,  6'd0,  6'd12}, 3, 1'b0, 64'h0000_0000_1C00_0000, 3'b001, 6'd12, 5};
    vecs[1] = '{3'b010, {6'd0,  6'd63, 6'd0 }, 2, 1'b1, 64'h8040_2010_0804_0201, 3'b010, 6'd63, 4};
    vecs[2] = '{3'b111, {6'd7,  6'd21, 6'd40}, 2, 1'b0, 64'h00FF_0000_0000_FF00, 3'b100, 6'd7,  4};
    vecs[3] = '{3'b011, {6'd1,  6'd2,  6'd3 }, 4, 1'b0, 64'h0000_0010_2800_4400, 3'b001, 6'd3,  6};
    vecs[4] = '{3'b101, {6'd50, 6'd17, 6'd9 }, 3, 1'b0, 64'h0000_0000_0000_0001, 3'b100, 6'd50, 5};
    vecs[5] = '{3'b110, {6'd44, 6'd30, 6'd5 }, 2, 1'b1, 64'hFFFF_FFFF_0000_0000, 3'b010, 6'd30, 4};
    vecs[6] = '{3'b001, {6'd0,  6'd0,  6'd0 }, 6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 6'd0,  8};

    reset     = 1'b1;
    req       = '0;
    req_pos   = '0;
    gen_ready = 1'b1;
    gen_moves = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Round-robin with all three requesting; pointer back to 2 so index 0 leads.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      logic [2:0] exp_order[4];
      logic [2:0] restore = '0;
      int         n = 0;
      int         tprev = -1;
      bit         bub = 1'b0;
      exp_order[0] = 3'b001;
      exp_order[1] = 3'b010;
      exp_order[2] = 3'b100;
      exp_order[3] = 3'b001;
      gm_stale = 1'b1;
      gm_lat   = 2;
      gm_moves = 64'h0000_0000_0000_8100;
      req_pos  = {6'd2, 6'd1, 6'd0};
      req      = 3'b111;
      for (int c = 1; c <= 80 && n < 4; c++) begin
        @(negedge clk);
        if (bub) begin
          chk($sformatf("rr_bubble%0d", n), 64'(grant), 64'd0);
          bub = 1'b0;
        end
        req     = req | restore;
        restore = '0;
        if (resp_valid != 3'b000) begin
          chk($sformatf("rr_order%0d", n), 64'(resp_valid), 64'(exp_order[n]));
          if (n > 0) chk($sformatf("rr_gap%0d", n), 64'(c - tprev), 64'd5);
          tprev   = c;
          n++;
          req     = req & ~resp_valid;
          restore = resp_valid;
          bub     = 1'b1;
          if (n == 4) req = 3'b000;
        end
      end
      chk("rr_grants", 64'(n), 64'd4);
    end
    @(negedge clk);

    // Requester 2 withdraws during WAIT; the transaction must still complete.
    begin
      int pulses = 0;
      int kseen  = -1;
      gm_stale = 1'b0;
      gm_lat   = 5;
      gm_moves = 64'h0000_0A00_0000_0000;
      req_pos  = {6'd27, 6'd0, 6'd0};
      req      = 3'b100;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 4) req = 3'b000;
        if (resp_valid[2]) begin
          pulses++;
          if (kseen < 0) kseen = k;
        end
      end
      chk("wd_pulses",  64'(pulses), 64'd1);
      chk("wd_latency", 64'(kseen),  64'd7);
      chk("wd_moves",   resp_moves,  64'h0000_0A00_0000_0000);
    end

    // Generator never answers.
    begin
      int          pulses = 0;
      int          kseen  = -1;
      logic        to_at  = 1'b0;
      logic [63:0] mv_at  = GARBAGE;
      gm_stale = 1'b0;
      gm_lat   = 1000;
      gm_moves = 64'h1234_5678_9ABC_DEF0;
      req_pos  = {6'd0, 6'd0, 6'd9};
      req      = 3'b001;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (resp_valid != 3'b000) begin
          pulses++;
          if (kseen < 0) begin
            kseen = k;
            to_at = resp_timeout;
            mv_at = resp_moves;
          end
          req = 3'b000;
        end
      end
`ifdef MOVEGEN_TIMEOUT_EN
      chk("to_pulses",  64'(pulses), 64'd1);
      chk("to_latency", 64'(kseen),  64'd13);
      chk("to_flag",    64'(to_at),  64'd1);
      chk("to_moves",   mv_at,       64'd0);
      chk("to_busy",    64'(busy),   64'd0);
`else
      chk("stall_pulses", 64'(pulses), 64'd0);
      chk("stall_busy",   64'(busy),   64'd1);
      chk("stall_grant",  64'(grant),  64'd1);
`endif
    end
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset in WAIT aborts silently and restores the pointer to NUM_REQ-1.
    begin
      int pulses = 0;
      gm_stale = 1'b0;
      gm_lat   = 10;
      gm_moves = 64'h0000_0000_00FF_0000;
      req_pos  = {6'd0, 6'd33, 6'd0};
      req      = 3'b010;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      chk("rstmid_in_wait", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("rstmid");
      reset = 1'b0;
      req   = 3'b000;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        if (resp_valid != 3'b000) pulses++;
      end
      chk("rstmid_no_resp", 64'(pulses), 64'd0);
    end
    begin
      vec_t v;
      v = '{3'b110, {6'd61, 6'd19, 6'd0}, 2, 1'b0, 64'h0000_0000_0000_0E0E, 3'b010, 6'd19, 4};
      run_txn(v, "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
